spi_master_ctrl: RTL

- SPI initiator that drives the SPI slave/RAM wrapper from a parallel command interface.
- Accepts one 2-bit command plus an 8-bit payload per handshake. Serialises it on MOSI inside one SS_n-low frame.
- For read-data commands (11), captures the 8-bit serial reply from MISO and returns it in parallel.
- Sits between a host/sequencer and the SPI_WRAPPER port pins; one SPI bit per clk cycle.

---
 rtl/spi_master_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI initiator turning one {cmd,wdata} handshake into one SS_n-low frame
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd[1:0], wdata[7:0]  00 wr addr, 01 wr data, 10 rd addr, 11 rd data; payload byte
//   rsp_valid, rsp_data   one-cycle pulse with the byte read on MISO (data holds until next read)
//   busy                  high from accept until the end of the inter-frame gap
//   SS_n, MOSI, MISO      SPI pins; SS_n and MOSI are registered, MSB first
module spi_master_ctrl #(
   parameter int RD_LAT = 2,
   parameter int GAP    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_WAIT, S_RECV, S_END} state_t;
   localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);
   localparam logic [3:0] GAP_M1 = 4'(GAP - 1);
   state_t     st, nst;
   logic [3:0] cnt, ncnt;
   logic [9:0] frame, nframe;
   logic [7:0] sh, nsh, nrd;
   logic       nss, nmosi, nrv, nbusy;
   assign cmd_ready = (st == S_IDLE);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= S_IDLE;
         cnt       <= '0;
         frame     <= '0;
         sh        <= '0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
      end else begin
         st        <= nst;
         cnt       <= ncnt;
         frame     <= nframe;
         sh        <= nsh;
         SS_n      <= nss;
         MOSI      <= nmosi;
         rsp_valid <= nrv;
         rsp_data  <= nrd;
         busy      <= nbusy;
      end
   end
   // Outputs are computed one cycle ahead so SS_n/MOSI come straight from flops.
   always_comb begin
      nst    = st;
      ncnt   = cnt;
      nframe = frame;
      nsh    = sh;
      nss    = SS_n;
      nmosi  = MOSI;
      nrv    = 1'b0;
      nrd    = rsp_data;
      nbusy  = busy;
      case (st)
         S_IDLE: if (cmd_valid) begin
            nst    = S_START;
            nframe = {cmd, wdata};
            nss    = 1'b0;
            nmosi  = cmd[1];
            nbusy  = 1'b1;
         end
         S_START: begin
            nst   = S_SHIFT;
            ncnt  = 4'd9;
            nmosi = frame[9];
         end
         S_SHIFT: if (cnt != 4'd0) begin
            ncnt  = cnt - 4'd1;
            nmosi = frame[ncnt];
         end else begin
            nmosi = 1'b0;
            if (frame[9:8] != 2'b11) begin
               nst  = S_END;
               nss  = 1'b1;
               ncnt = GAP_M1;
            end else if (RD_LAT == 0) begin
               nst  = S_RECV;
               ncnt = 4'd7;
            end else begin
               nst  = S_WAIT;
               ncnt = LAT_M1;
            end
         end
         S_WAIT: if (cnt != 4'd0) ncnt = cnt - 4'd1;
         else begin
            nst  = S_RECV;
            ncnt = 4'd7;
         end
         S_RECV: begin
            nsh = {sh[6:0], MISO};
            if (cnt != 4'd0) ncnt = cnt - 4'd1;
            else begin
               nst  = S_END;
               nss  = 1'b1;
               ncnt = GAP_M1;
               nrd  = nsh;
               nrv  = 1'b1;
            end
         end
         S_END: if (cnt != 4'd0) ncnt = cnt - 4'd1;
         else begin
            nst   = S_IDLE;
            nbusy = 1'b0;
         end
         default: nst = S_IDLE;
      endcase
   end
endmodule
